controller_reduce_seq: RTL and testbench

// Operator-reduction sequencer between the input decoder and the operator/data stacks and ALU.
// On each accepted operator it pops and evaluates stacked operators while the precedence ROM says
// top-of-stack binds tighter, then pushes the new operator. On flush ('=') it reduces until the op

---
 rtl/controller_reduce_seq.sv | 176 +++++++++++++++++
 tb/tb_controller_reduce_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_reduce_seq.sv
// Operator-reduction sequencer: pops and evaluates stacked operators by precedence, then pushes the new one.
// Optional ALU watchdog enabled by defining CONT_ALU_WDOG_EN.
module controller_reduce_seq #(
    parameter int OP_W = 4,
    parameter int DW   = 32,
    parameter int WDOG = 64
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            req_valid,
    input  logic [OP_W-1:0] req_op,
    input  logic            req_flush,
    output logic            req_ready,
    output logic [1:0]      os_cmd,
    output logic [OP_W-1:0] os_wdata,
    input  logic [OP_W-1:0] os_top,
    input  logic            os_empty,
    output logic [1:0]      ds_cmd,
    output logic [DW-1:0]   ds_wdata,
    input  logic [DW-1:0]   ds_top,
    input  logic            ds_empty,
    output logic [OP_W-1:0] pr_a,
    output logic [OP_W-1:0] pr_b,
    input  logic            pr_res,
    output logic            al_start,
    output logic [OP_W-1:0] al_op,
    output logic [DW-1:0]   al_A,
    output logic [DW-1:0]   al_B,
    input  logic            al_done,
    input  logic [DW-1:0]   al_C,
    output logic            busy,
    output logic            err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CMP   = 4'd1;
    localparam logic [3:0] S_POPO  = 4'd2;
    localparam logic [3:0] S_POPB  = 4'd3;
    localparam logic [3:0] S_POPA  = 4'd4;
    localparam logic [3:0] S_EXEC  = 4'd5;
    localparam logic [3:0] S_WAIT  = 4'd6;
    localparam logic [3:0] S_PUSHR = 4'd7;
    localparam logic [3:0] S_PUSHO = 4'd8;
    localparam logic [3:0] S_ERR   = 4'd9;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;

    logic [3:0]      state;
    logic [OP_W-1:0] op_q;
    logic            flush_q;

`ifdef CONT_ALU_WDOG_EN
    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
            os_cmd    <= CMD_NONE;
            os_wdata  <= '0;
            ds_cmd    <= CMD_NONE;
            ds_wdata  <= '0;
            pr_a      <= '0;
            pr_b      <= '0;
            al_start  <= 1'b0;
            al_op     <= '0;
            al_A      <= '0;
            al_B      <= '0;
            op_q      <= '0;
            flush_q   <= 1'b0;
`ifdef CONT_ALU_WDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            // The op stack never changes in the cycle before CMP, so a registered copy of its top is current there.
            pr_a     <= os_top;
            os_cmd   <= CMD_NONE;
            os_wdata <= '0;
            ds_cmd   <= CMD_NONE;
            ds_wdata <= '0;
            al_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        flush_q   <= req_flush;
                        pr_b      <= req_op;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (os_empty && flush_q) begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (!os_empty && (flush_q || pr_res)) begin
                        os_cmd <= CMD_POP;
                        al_op  <= os_top;
                        state  <= S_POPO;
                    end else begin
                        if (op_q != '0) begin
                            os_cmd   <= CMD_PUSH;
                            os_wdata <= op_q;
                        end
                        state <= S_PUSHO;
                    end
                end
                S_POPO: begin
                    if (ds_empty) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        al_B   <= ds_top;
                        ds_cmd <= CMD_POP;
                        state  <= S_POPB;
                    end
                end
                S_POPB: state <= S_POPA;
                // B has left the data stack by now, so ds_top/ds_empty describe operand A.
                S_POPA: begin
                    if (ds_empty) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        al_A     <= ds_top;
                        ds_cmd   <= CMD_POP;
                        al_start <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef CONT_ALU_WDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (al_done) begin
                        ds_cmd   <= CMD_PUSH;
                        ds_wdata <= al_C;
                        state    <= S_PUSHR;
                    end
`ifdef CONT_ALU_WDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_PUSHR: state <= S_CMP;
                S_PUSHO: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_ERR: state <= S_ERR;
                default: begin
                    err   <= 1'b1;
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_reduce_seq.sv
// Directed bench for controller_reduce_seq with behavioural op/data stacks, precedence ROM and ALU.
// Codes: 1 '+', 2 '*', 3 '-'.
module tb_controller_reduce_seq;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic        req_flush = 1'b0;
    logic        req_ready;
    logic [1:0]  os_cmd;
    logic [3:0]  os_wdata;
    logic [3:0]  os_top;
    logic        os_empty;
    logic [1:0]  ds_cmd;
    logic [31:0] ds_wdata;
    logic [31:0] ds_top;
    logic        ds_empty;
    logic [3:0]  pr_a, pr_b;
    logic        pr_res;
    logic        al_start;
    logic [3:0]  al_op;
    logic [31:0] al_A, al_B;
    logic        al_done;
    logic [31:0] al_C;
    logic        busy;
    logic        err;

    controller_reduce_seq #(.OP_W(4), .DW(32), .WDOG(64)) dut (
        .Clock(Clock), .Reset(Reset), .req_valid(req_valid), .req_op(req_op),
        .req_flush(req_flush), .req_ready(req_ready), .os_cmd(os_cmd), .os_wdata(os_wdata),
        .os_top(os_top), .os_empty(os_empty), .ds_cmd(ds_cmd), .ds_wdata(ds_wdata),
        .ds_top(ds_top), .ds_empty(ds_empty), .pr_a(pr_a), .pr_b(pr_b), .pr_res(pr_res),
        .al_start(al_start), .al_op(al_op), .al_A(al_A), .al_B(al_B), .al_done(al_done),
        .al_C(al_C), .busy(busy), .err(err)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Stack models
    logic        m_clr = 1'b1;
    logic        ld_os = 1'b0, ld_ds = 1'b0;
    logic [3:0]  ld_os_v = 4'd0;
    logic [31:0] ld_ds_v = 32'd0;
    logic [3:0]  os_mem [32];
    logic [31:0] ds_mem [32];
    logic [31:0] ds_log [32];
    logic [4:0]  os_sp, ds_sp, ds_nlog;

    always @(posedge Clock) begin
        if (m_clr) begin
            os_sp <= '0; ds_sp <= '0; ds_nlog <= '0;
        end else begin
            if (ld_os) begin
                os_mem[os_sp] <= ld_os_v; os_sp <= os_sp + 5'd1;
            end else if (os_cmd == 2'b01) begin
                os_mem[os_sp] <= os_wdata; os_sp <= os_sp + 5'd1;
            end else if (os_cmd == 2'b10 && os_sp != 0) begin
                os_sp <= os_sp - 5'd1;
            end
            if (ld_ds) begin
                ds_mem[ds_sp] <= ld_ds_v; ds_sp <= ds_sp + 5'd1;
            end else if (ds_cmd == 2'b01) begin
                ds_mem[ds_sp] <= ds_wdata; ds_sp <= ds_sp + 5'd1;
                ds_log[ds_nlog] <= ds_wdata; ds_nlog <= ds_nlog + 5'd1;
            end else if (ds_cmd == 2'b10 && ds_sp != 0) begin
                ds_sp <= ds_sp - 5'd1;
            end
        end
    end

    assign os_top   = (os_sp != 0) ? os_mem[os_sp - 5'd1] : 4'd0;
    assign os_empty = (os_sp == 0);
    assign ds_top   = (ds_sp != 0) ? ds_mem[ds_sp - 5'd1] : 32'd0;
    assign ds_empty = (ds_sp == 0);

    // Precedence ROM: left-associative, '*' binds tighter than '+'/'-'
    function automatic int prec(input logic [3:0] op);
        case (op)
            4'd1, 4'd3: prec = 1;
            4'd2:       prec = 2;
            default:    prec = 0;
        endcase
    endfunction
    assign pr_res = (prec(pr_a) >= prec(pr_b));

    // ALU model: result two cycles after the start pulse is seen, unless hung
    logic        alu_hang = 1'b0;
    int          n_start;
    int          alu_cnt;
    logic [3:0]  cap_op;
    logic [31:0] cap_A, cap_B;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    alu_f = a + b;
            4'd2:    alu_f = a * b;
            4'd3:    alu_f = a - b;
            default: alu_f = 32'd0;
        endcase
    endfunction

    always @(posedge Clock) begin
        al_done <= 1'b0;
        if (m_clr) begin
            n_start <= 0; alu_cnt <= 0; al_C <= 32'd0;
        end else if (al_start) begin
            n_start <= n_start + 1;
            cap_op <= al_op; cap_A <= al_A; cap_B <= al_B;
            alu_cnt <= alu_hang ? 0 : 2;
        end else if (alu_cnt != 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) begin
                al_done <= 1'b1;
                al_C <= alu_f(cap_op, cap_A, cap_B);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0; m_clr = 1'b1; req_valid = 1'b0; alu_hang = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1; m_clr = 1'b0;
    endtask

    task automatic push_os(input logic [3:0] v);
        @(negedge Clock); ld_os = 1'b1; ld_os_v = v;
        @(negedge Clock); ld_os = 1'b0;
    endtask

    task automatic push_ds(input logic [31:0] v);
        @(negedge Clock); ld_ds = 1'b1; ld_ds_v = v;
        @(negedge Clock); ld_ds = 1'b0;
    endtask

    // Returns at the falling edge of the cycle after the accepting edge.
    task automatic send(input logic [3:0] op, input logic fl);
        @(negedge Clock);
        req_valid = 1'b1; req_op = op; req_flush = fl;
        @(negedge Clock);
        req_valid = 1'b0; req_op = 4'd0; req_flush = 1'b0;
    endtask

    task automatic wait_ready(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge Clock);
        end
    endtask

    task automatic wait_start(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (n_start != 0) begin ok = 1'b1; break; end
            @(negedge Clock);
        end
    endtask

    initial begin
        logic ok;

        // Reset state
        do_reset();
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_os_cmd", os_cmd, 0);
        check("rst_ds_cmd", ds_cmd, 0);
        check("rst_al_start", al_start, 0);

        // Empty op stack, push '+': push visible on the second cycle after accept
        send(4'd1, 1'b0);
        check("plus_cmp_os_cmd", os_cmd, 0);
        check("plus_busy", busy, 1);
        @(negedge Clock);
        check("plus_os_cmd", os_cmd, 2'b01);
        check("plus_os_wdata", os_wdata, 4'd1);
        @(negedge Clock);
        check("plus_ready", req_ready, 1);
        check("plus_os_depth", os_sp, 1);
        check("plus_os_val", os_mem[0], 4'd1);
        check("plus_no_alu", n_start, 0);

        // Stack '*', data 3,4; push '+' -> 3*4=12 then '+' pushed
        do_reset();
        push_os(4'd2); push_ds(32'd3); push_ds(32'd4);
        send(4'd1, 1'b0);
        wait_ready(60, ok);
        check("red_done", ok, 1);
        check("red_alu_cnt", n_start, 1);
        check("red_al_op", cap_op, 4'd2);
        check("red_al_A", cap_A, 32'd3);
        check("red_al_B", cap_B, 32'd4);
        check("red_ds_log", ds_log[0], 32'd12);
        check("red_ds_depth", ds_sp, 1);
        check("red_ds_top", ds_mem[0], 32'd12);
        check("red_os_depth", os_sp, 1);
        check("red_os_top", os_mem[0], 4'd1);

        // Stack '+', data 7; push '*' -> no pop, data untouched
        do_reset();
        push_os(4'd1); push_ds(32'd7);
        send(4'd2, 1'b0);
        wait_ready(60, ok);
        check("nored_done", ok, 1);
        check("nored_alu_cnt", n_start, 0);
        check("nored_os_depth", os_sp, 2);
        check("nored_os_top", os_mem[1], 4'd2);
        check("nored_ds_depth", ds_sp, 1);
        check("nored_ds_top", ds_mem[0], 32'd7);

        // Stack '+','*', data 2,3,4; flush -> 12 then 14
        do_reset();
        push_os(4'd1); push_os(4'd2);
        push_ds(32'd2); push_ds(32'd3); push_ds(32'd4);
        send(4'd0, 1'b1);
        wait_ready(100, ok);
        check("flush_done", ok, 1);
        check("flush_alu_cnt", n_start, 2);
        check("flush_push1", ds_log[0], 32'd12);
        check("flush_push2", ds_log[1], 32'd14);
        check("flush_last_A", cap_A, 32'd2);
        check("flush_last_B", cap_B, 32'd12);
        check("flush_os_depth", os_sp, 0);
        check("flush_ds_depth", ds_sp, 1);
        check("flush_ds_top", ds_mem[0], 32'd14);
        check("flush_err", err, 0);

        // Op code 0 without flush: nothing pushed
        send(4'd0, 1'b0);
        @(negedge Clock);
        check("nop_os_cmd", os_cmd, 0);
        wait_ready(10, ok);
        check("nop_done", ok, 1);
        check("nop_os_depth", os_sp, 0);

        // Flush on empty op stack: straight back to idle
        send(4'd0, 1'b1);
        @(negedge Clock);
        check("eflush_ready", req_ready, 1);
        check("eflush_ds_depth", ds_sp, 1);

        // Reset in the middle of WAIT
        do_reset();
        push_os(4'd2); push_ds(32'd3); push_ds(32'd4);
        alu_hang = 1'b1;
        send(4'd1, 1'b0);
        wait_start(20, ok);
        check("wait_started", ok, 1);
        repeat (3) @(negedge Clock);
        check("wait_busy", busy, 1);
        Reset = 1'b0;
        @(negedge Clock);
        check("mrst_ready", req_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_err", err, 0);
        check("mrst_os_cmd", os_cmd, 0);
        check("mrst_ds_cmd", ds_cmd, 0);
        check("mrst_al_start", al_start, 0);
        Reset = 1'b1;
        alu_hang = 1'b0;

        // One operand under '+': underflow error, sticky until reset
        do_reset();
        push_os(4'd1); push_ds(32'd5);
        send(4'd0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (err) begin ok = 1'b1; break; end
            @(negedge Clock);
        end
        check("uflow_err", ok, 1);
        check("uflow_no_alu", n_start, 0);
        send(4'd1, 1'b0);
        repeat (4) @(negedge Clock);
        check("uflow_ready_held", req_ready, 0);
        check("uflow_err_held", err, 1);
        check("uflow_busy", busy, 1);
        check("uflow_os_cmd", os_cmd, 0);
        check("uflow_ds_cmd", ds_cmd, 0);
        do_reset();
        check("uflow_clr_err", err, 0);
        check("uflow_clr_ready", req_ready, 1);

`ifdef CONT_ALU_WDOG_EN
        // Hung ALU: watchdog trips after 64 WAIT cycles
        do_reset();
        push_os(4'd2); push_ds(32'd3); push_ds(32'd4);
        alu_hang = 1'b1;
        send(4'd1, 1'b0);
        wait_start(20, ok);
        check("wdog_started", ok, 1);
        repeat (40) @(negedge Clock);
        check("wdog_early", err, 0);
        repeat (40) @(negedge Clock);
        check("wdog_err", err, 1);
        check("wdog_ready", req_ready, 0);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
